// File: rtl/aes_key_expand.sv
// Iterative AES-128/192/256 key schedule: one 32-bit word per cycle through a single 4-byte S-box.
// Optional build macro AES_KEYEXP_MASK_EN zeroes key_words_o while ready_o is low.
module aes_key_expand (
  input  logic                eph1,
  input  logic                reset,
  input  logic                start,
  input  logic [255:0]        key_i,
  input  logic [1:0]          key_size_i,
  output logic [15:1][127:0]  key_words_o,
  output logic                ready_o,
  output logic                busy_o
);

  localparam logic [0:255][7:0] SBox = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {StIdle, StLoad, StExpand, StDone} state_e;

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {SBox[x[31:24]], SBox[x[23:16]], SBox[x[15:8]], SBox[x[7:0]]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  state_e      state_q, state_d;
  logic [31:0] w_q [60];
  logic [5:0]  i_q, i_d;
  logic [2:0]  j_q, j_d;
  logic [7:0]  rcon_q, rcon_d;
  logic [1:0]  size_q, size_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        load_en, expand_en;

  logic [3:0]  nk, nk_in;
  logic [5:0]  t_last;
  logic [5:0]  idx_prev, idx_old;
  logic [31:0] prev_word, old_word, sub_in, sub_out, t_word, new_word;

  always_comb begin
    unique case (size_q)
      2'b00:   begin nk = 4'd4; t_last = 6'd43; end
      2'b01:   begin nk = 4'd6; t_last = 6'd51; end
      default: begin nk = 4'd8; t_last = 6'd59; end
    endcase
    unique case (key_size_i)
      2'b00:   nk_in = 4'd4;
      2'b01:   nk_in = 4'd6;
      default: nk_in = 4'd8;
    endcase
  end

  // Datapath for the word at index i; only consumed in StExpand where i >= Nk.
  always_comb begin
    idx_prev  = i_q - 6'd1;
    idx_old   = i_q - {2'b00, nk};
    prev_word = (idx_prev < 6'd60) ? w_q[idx_prev] : '0;
    old_word  = (idx_old < 6'd60) ? w_q[idx_old] : '0;
    sub_in    = (j_q == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
    sub_out   = sub_word(sub_in);
    if (j_q == 3'd0) begin
      t_word = sub_out ^ {rcon_q, 24'h0};
    end else if (nk == 4'd8 && j_q == 3'd4) begin
      t_word = sub_out;
    end else begin
      t_word = prev_word;
    end
    new_word = old_word ^ t_word;
  end

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    rcon_d    = rcon_q;
    size_d    = size_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    load_en   = 1'b0;
    expand_en = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          load_en = 1'b1;
          state_d = StLoad;
          size_d  = key_size_i;
          i_d     = {2'b00, nk_in};
          j_d     = 3'd0;
          rcon_d  = 8'h01;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      StLoad: begin
        state_d = StExpand;
      end
      StExpand: begin
        expand_en = 1'b1;
        i_d       = i_q + 6'd1;
        j_d       = ({1'b0, j_q} == nk - 4'd1) ? 3'd0 : j_q + 3'd1;
        if (j_q == 3'd0) begin
          rcon_d = xtime(rcon_q);
        end
        if (i_q == t_last) begin
          state_d = StDone;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge eph1) begin
    if (!reset) begin
      state_q <= StIdle;
      i_q     <= '0;
      j_q     <= '0;
      rcon_q  <= 8'h01;
      size_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      rcon_q  <= rcon_d;
      size_q  <= size_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Load clears the whole file so unused round-key slots read as zero.
  always_ff @(posedge eph1) begin
    if (!reset) begin
      for (int k = 0; k < 60; k++) begin
        w_q[k] <= '0;
      end
    end else if (load_en) begin
      for (int k = 0; k < 8; k++) begin
        w_q[k] <= (k < int'(nk_in)) ? key_i[255 - 32*k -: 32] : 32'h0;
      end
      for (int k = 8; k < 60; k++) begin
        w_q[k] <= '0;
      end
    end else if (expand_en) begin
      for (int k = 0; k < 60; k++) begin
        if (i_q == 6'(k)) begin
          w_q[k] <= new_word;
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < 15; r++) begin
`ifdef AES_KEYEXP_MASK_EN
      key_words_o[15-r] = ready_q ? {w_q[4*r], w_q[4*r+1], w_q[4*r+2], w_q[4*r+3]} : 128'h0;
`else
      key_words_o[15-r] = {w_q[4*r], w_q[4*r+1], w_q[4*r+2], w_q[4*r+3]};
`endif
    end
  end

  assign ready_o = ready_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed vectors for aes_key_expand: FIPS-197 A.1-A.3, a 256-bit team key,
// mid-expansion start/reset, back-to-back restart and reset-gated start.
module tb_aes_key_expand;

  logic               eph1;
  logic               reset;
  logic               start;
  logic [255:0]       key_i;
  logic [1:0]         key_size_i;
  logic [15:1][127:0] key_words_o;
  logic               ready_o;
  logic               busy_o;

  int n_cmp = 0;
  int n_err = 0;

  aes_key_expand dut (
    .eph1        (eph1),
    .reset       (reset),
    .start       (start),
    .key_i       (key_i),
    .key_size_i  (key_size_i),
    .key_words_o (key_words_o),
    .ready_o     (ready_o),
    .busy_o      (busy_o)
  );

  initial eph1 = 1'b0;
  always #5 eph1 = ~eph1;

  typedef struct {
    logic [255:0] key;
    logic [1:0]   size;
    int           lat;
    int           idx_a;
    logic [127:0] exp_a;
    int           idx_b;
    logic [127:0] exp_b;
    int           zero_top;
  } vec_t;

  vec_t vecs [4];

  task automatic tick();
    @(posedge eph1);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts an expansion; optionally pokes start at cycle poke_at or drops reset at rst_at.
  // lat = cycles from start edge to ready_o, 0 if aborted by reset, -1 on timeout.
  task automatic expand(input logic [255:0] key, input logic [1:0] size, input int poke_at,
                        input int rst_at, output int lat);
    key_i      = key;
    key_size_i = size;
    start      = 1'b1;
    tick();
    start = 1'b0;
    key_i = ~key;
    check("busy_after_start", {127'h0, busy_o}, 128'h1);
    check("ready_after_start", {127'h0, ready_o}, 128'h0);
`ifdef AES_KEYEXP_MASK_EN
    check("masked_during_load", {127'h0, |key_words_o}, 128'h0);
`else
    check("key_visible_after_load", key_words_o[15], key[255:128]);
`endif
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      if (n == poke_at) begin
        start      = 1'b1;
        key_size_i = 2'b11;
      end
      if (n == rst_at) reset = 1'b0;
      tick();
      start = 1'b0;
      if (n == rst_at) begin
        reset = 1'b1;
        check("abort_ready", {127'h0, ready_o}, 128'h0);
        check("abort_busy", {127'h0, busy_o}, 128'h0);
        check("abort_kw_zero", {127'h0, |key_words_o}, 128'h0);
        lat = 0;
        break;
      end
      if (busy_o && ready_o) check("busy_ready_exclusive", 128'h1, 128'h0);
`ifdef AES_KEYEXP_MASK_EN
      if (!ready_o) check("masked_gap", {127'h0, |key_words_o}, 128'h0);
`endif
      if (ready_o) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) check("ready_timeout", 128'h0, 128'h1);
  endtask

  task automatic check_vec(input vec_t v, input int lat);
    check("latency", 128'(lat), 128'(v.lat));
    check("busy_done", {127'h0, busy_o}, 128'h0);
    check("rk0_is_key", key_words_o[15], v.key[255:128]);
    check("rk_a", key_words_o[v.idx_a], v.exp_a);
    check("rk_b", key_words_o[v.idx_b], v.exp_b);
    for (int k = 1; k <= v.zero_top; k++) check("unused_zero", key_words_o[k], 128'h0);
  endtask

  initial begin
    int lat;
    vecs[0] = '{key: {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeef0badf00d1234567899aabbcc},
                size: 2'b00, lat: 41,
                idx_a: 14, exp_a: 128'ha0fafe1788542cb123a339392a6c7605,
                idx_b: 5,  exp_b: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, zero_top: 4};
    vecs[1] = '{key: {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0123456789abcdef},
                size: 2'b01, lat: 47,
                idx_a: 13, exp_a: 128'hec12068e6c827f6b0e7a95b95c56fec2,
                idx_b: 3,  exp_b: 128'he98ba06f448c773c8ecc720401002202, zero_top: 2};
    vecs[2] = '{key: 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                size: 2'b11, lat: 53,
                idx_a: 13, exp_a: 128'h9ba354118e6925afa51a8b5f2067fcde,
                idx_b: 1,  exp_b: 128'hfe4890d1e6188d0b046df344706c631e, zero_top: 0};
    vecs[3] = '{key: 256'hF01F2E724AC0AB35BE3A20FF7A7D7FCA_D005A3321BBF085C2BC611AE8820839D,
                size: 2'b10, lat: 53,
                idx_a: 15, exp_a: 128'hF01F2E724AC0AB35BE3A20FF7A7D7FCA,
                idx_b: 14, exp_b: 128'hD005A3321BBF085C2BC611AE8820839D, zero_top: 0};

    reset      = 1'b0;
    start      = 1'b0;
    key_i      = '0;
    key_size_i = 2'b00;
    repeat (3) tick();
    reset = 1'b1;
    check("reset_ready", {127'h0, ready_o}, 128'h0);
    check("reset_busy", {127'h0, busy_o}, 128'h0);
    check("reset_kw_zero", {127'h0, |key_words_o}, 128'h0);

    for (int v = 0; v < 4; v++) begin
      expand(vecs[v].key, vecs[v].size, 0, 0, lat);
      check_vec(vecs[v], lat);
    end

    // Start pulse with a different key mid-expansion is ignored.
    expand(vecs[0].key, vecs[0].size, 10, 0, lat);
    check_vec(vecs[0], lat);

    // Reset at cycle 20 aborts, then a fresh run completes normally.
    expand(vecs[0].key, vecs[0].size, 0, 20, lat);
    check("abort_lat", 128'(lat), 128'h0);
    expand(vecs[0].key, vecs[0].size, 0, 0, lat);
    check_vec(vecs[0], lat);

    // Back-to-back restart from DONE with the A.3 key.
    check("ready_before_restart", {127'h0, ready_o}, 128'h1);
    expand(vecs[2].key, vecs[2].size, 0, 0, lat);
    check_vec(vecs[2], lat);

    // Start while reset is low is ignored.
    reset = 1'b0;
    start = 1'b1;
    tick();
    reset = 1'b1;
    start = 1'b0;
    tick();
    check("start_in_reset_busy", {127'h0, busy_o}, 128'h0);
    check("start_in_reset_ready", {127'h0, ready_o}, 128'h0);
    check("start_in_reset_kw", {127'h0, |key_words_o}, 128'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
